cordic_scheduler: RTL and testbench
===================================

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 16, operand and result word width.
- SECTOR_FLAG_WIDTH, 2, sector tag width.
- LATENCY, 6, fixed CORDIC pipeline latency in cycles.
- RESULT_DEPTH, 8, result FIFO entries, power of two.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous active-low reset.
- rN_valid, in, 1, requester N (N=0,1) has an operation.
- rN_ready, out, 1, requester N operation accepted this cycle.
- rN_arctan_en, in, 1, 1 = vectoring (arctan), 0 = rotation.
- rN_degree / rN_x / rN_y, in, DATA_WIDTH each, signed operands.
- rN_sector, in, SECTOR_FLAG_WIDTH, sector tag carried through.
- pl_valid / pl_arctan_en / pl_sector / pl_degree / pl_x / pl_y, out, to CORDIC pipeline inputs.
- pl_valid_out / pl_arctan_en_out / pl_sector_out / pl_degree_out / pl_x_out / pl_y_out, in, from CORDIC pipeline outputs.
- res_valid, out, 1, result FIFO head valid.
- res_ready, in, 1, consumer takes head.
- res_id, out, 1, requester that issued the head result.
- res_arctan_en / res_sector / res_degree / res_x / res_y, out, head fields.
- err_tag, out, 1, sticky tag-alignment error.

Function
REQ-003 The block SHALL share one CORDIC pipeline between two requesters, issuing at most one operation per cycle.
REQ-004 Issue SHALL be allowed only when occupancy + in_flight < RESULT_DEPTH, so the non-stallable pipeline never overflows the FIFO.
REQ-005 Occupancy SHALL count FIFO entries; in_flight SHALL count issued operations not yet returned (0..LATENCY).
REQ-006 A FIFO pop in the same cycle SHALL NOT free credit for that cycle's issue; credit is evaluated on registered counts only.
REQ-007 Arbitration SHALL be round-robin: when both valid, the requester not granted last SHALL win; a single valid requester SHALL win.
REQ-008 The round-robin pointer SHALL update only on a grant; it SHALL be 0-priority after reset.
REQ-009 rN_ready SHALL be combinational: high exactly in the cycle requester N is granted.
REQ-010 pl_* outputs SHALL be combinational muxes of the granted requester's fields; with no grant, pl_valid SHALL be 0 and the other pl_* fields 0.
REQ-011 A LATENCY-deep tag shift register SHALL carry {valid, id} per issue so that tag stage LATENCY aligns with pl_valid_out.
REQ-012 When pl_valid_out=1, the block SHALL write {id, pl_arctan_en_out, pl_sector_out, pl_degree_out, pl_x_out, pl_y_out} to the FIFO tail.
REQ-013 The FIFO SHALL use wrapping read and write pointers of log2(RESULT_DEPTH) bits.
REQ-014 FIFO full and empty SHALL be derived from occupancy.
REQ-015 Simultaneous push and pop SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-016 res_valid SHALL equal (occupancy != 0); res_* SHALL present the head entry.
REQ-017 A pop SHALL occur on res_valid && res_ready.
REQ-018 in_flight SHALL increment on issue and decrement on pl_valid_out; simultaneous increment and decrement SHALL leave it unchanged.
REQ-019 If pl_valid_out differs from the aligned tag valid bit, err_tag SHALL set and stay 1 until reset.
REQ-020 On a tag mismatch the result SHALL still be written when pl_valid_out=1, and in_flight SHALL saturate at 0.
REQ-021 Issue-to-res_valid latency SHALL be LATENCY+1 cycles when the FIFO is empty.

Reset
REQ-022 reset low SHALL asynchronously clear: pointers, occupancy, in_flight, tag register, round-robin pointer (to 0), and err_tag.
REQ-023 During reset, all outputs SHALL be 0.
REQ-024 reset asserted mid-operation SHALL discard all in-flight and buffered results; the pipeline shares the same reset.

Verification
REQ-025 Single rotation: r0 issues degree=0x2D00 (45.0), sector=2; after 7 cycles res_valid=1, res_id=0, res_sector=2, res_x≈res_y≈0x00B5, res_degree≈0x2D00.
REQ-026 Contention: r0 and r1 valid continuously; grants SHALL alternate 0,1,0,1.
REQ-027 Contention results: res_id sequence SHALL match the grant order with no gaps.
REQ-028 Backpressure: res_ready=0 with both requesters streaming; exactly 8 issues, then rN_ready=0.
REQ-029 Backpressure release: res_ready=1 for 1 cycle frees exactly 1 credit, visible 1 cycle later.
REQ-030 Full FIFO: push and pop in the same cycle; occupancy SHALL stay 8 with no data loss or duplication.
REQ-031 Reset mid-stream: reset low for 1 cycle with 4 in flight; no res_valid SHALL appear for the next 10 cycles, and err_tag=0.
REQ-032 Tag mismatch: inject a spurious pl_valid_out=1 with no issue; err_tag=1 next cycle and SHALL stay 1 until reset.

Source files
------------

// File: rtl/cordic_scheduler_if.sv
// Bundle of requester, CORDIC-pipeline and result-FIFO signals around cordic_scheduler.
// The scheduler uses the slave modport; the environment uses the master modport.
interface cordic_scheduler_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int SECTOR_FLAG_WIDTH = 2
);
  // Handshake: a transfer happens in a cycle where valid and ready are both 1.
  // A source holds valid and its fields steady until that cycle. rN_ready and
  // pl_valid are combinational. The pipeline return path (pl_*_out) has no ready.
  // res_* may change only after a pop.
  logic                         r0_valid, r0_ready, r0_arctan_en;
  logic [DATA_WIDTH-1:0]        r0_degree, r0_x, r0_y;      // signed operands
  logic [SECTOR_FLAG_WIDTH-1:0] r0_sector;
  logic                         r1_valid, r1_ready, r1_arctan_en;
  logic [DATA_WIDTH-1:0]        r1_degree, r1_x, r1_y;
  logic [SECTOR_FLAG_WIDTH-1:0] r1_sector;

  logic                         pl_valid, pl_arctan_en;
  logic [SECTOR_FLAG_WIDTH-1:0] pl_sector;
  logic [DATA_WIDTH-1:0]        pl_degree, pl_x, pl_y;
  logic                         pl_valid_out, pl_arctan_en_out;
  logic [SECTOR_FLAG_WIDTH-1:0] pl_sector_out;
  logic [DATA_WIDTH-1:0]        pl_degree_out, pl_x_out, pl_y_out;

  logic                         res_valid, res_ready, res_id, res_arctan_en;
  logic [SECTOR_FLAG_WIDTH-1:0] res_sector;
  logic [DATA_WIDTH-1:0]        res_degree, res_x, res_y;
  logic                         err_tag;

  modport slave (
    input  r0_valid, r0_arctan_en, r0_degree, r0_x, r0_y, r0_sector,
    input  r1_valid, r1_arctan_en, r1_degree, r1_x, r1_y, r1_sector,
    output r0_ready, r1_ready,
    output pl_valid, pl_arctan_en, pl_sector, pl_degree, pl_x, pl_y,
    input  pl_valid_out, pl_arctan_en_out, pl_sector_out, pl_degree_out, pl_x_out, pl_y_out,
    output res_valid, res_id, res_arctan_en, res_sector, res_degree, res_x, res_y,
    input  res_ready,
    output err_tag
  );

  modport master (
    output r0_valid, r0_arctan_en, r0_degree, r0_x, r0_y, r0_sector,
    output r1_valid, r1_arctan_en, r1_degree, r1_x, r1_y, r1_sector,
    input  r0_ready, r1_ready,
    input  pl_valid, pl_arctan_en, pl_sector, pl_degree, pl_x, pl_y,
    output pl_valid_out, pl_arctan_en_out, pl_sector_out, pl_degree_out, pl_x_out, pl_y_out,
    input  res_valid, res_id, res_arctan_en, res_sector, res_degree, res_x, res_y,
    output res_ready,
    input  err_tag
  );
endinterface

// File: rtl/cordic_scheduler.sv
// Round-robin sharing of one fixed-latency CORDIC pipeline between two requesters,
// with credit-based issue so every returning result always has a FIFO slot.
module cordic_scheduler #(
  parameter int DATA_WIDTH        = 16,
  parameter int SECTOR_FLAG_WIDTH = 2,
  parameter int LATENCY           = 6,
  parameter int RESULT_DEPTH      = 8
) (
  input logic              clk,
  input logic              reset,
  cordic_scheduler_if.slave bus
);
  localparam int PW = $clog2(RESULT_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic                         id;
    logic                         arctan_en;
    logic [SECTOR_FLAG_WIDTH-1:0] sector;
    logic [DATA_WIDTH-1:0]        degree;
    logic [DATA_WIDTH-1:0]        x;
    logic [DATA_WIDTH-1:0]        y;
  } entry_t;

  logic [CW-1:0]      occ_q, occ_d;
  logic [FW-1:0]      infl_q, infl_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LATENCY-1:0] tag_v_q, tag_id_q;
  logic               rr_q;
  logic               err_q;
  entry_t             mem_q [RESULT_DEPTH];

  logic        credit, issue, gnt_id, push, pop, empty, full, tag_err;
  logic [31:0] budget;
  entry_t      wr_entry, res_e;

  // rr_q names the requester that wins the next tie; grants are masked in reset.
  always_comb begin
    budget = 32'(occ_q) + 32'(infl_q);
    credit = budget < 32'(RESULT_DEPTH);
    issue  = 1'b0;
    gnt_id = 1'b0;
    if (reset && credit) begin
      if (bus.r0_valid && bus.r1_valid) begin
        issue  = 1'b1;
        gnt_id = rr_q;
      end else if (bus.r0_valid || bus.r1_valid) begin
        issue  = 1'b1;
        gnt_id = bus.r1_valid;
      end
    end
  end

  assign bus.r0_ready = issue && !gnt_id;
  assign bus.r1_ready = issue && gnt_id;

  always_comb begin
    bus.pl_valid     = issue;
    bus.pl_arctan_en = 1'b0;
    bus.pl_sector    = '0;
    bus.pl_degree    = '0;
    bus.pl_x         = '0;
    bus.pl_y         = '0;
    if (issue) begin
      if (gnt_id) begin
        bus.pl_arctan_en = bus.r1_arctan_en;
        bus.pl_sector    = bus.r1_sector;
        bus.pl_degree    = bus.r1_degree;
        bus.pl_x         = bus.r1_x;
        bus.pl_y         = bus.r1_y;
      end else begin
        bus.pl_arctan_en = bus.r0_arctan_en;
        bus.pl_sector    = bus.r0_sector;
        bus.pl_degree    = bus.r0_degree;
        bus.pl_x         = bus.r0_x;
        bus.pl_y         = bus.r0_y;
      end
    end
  end

  // Tag stage LATENCY-1 lines up with the pipeline's pl_valid_out.
  always_comb begin
    empty    = (occ_q == '0);
    full     = (occ_q == CW'(RESULT_DEPTH));
    pop      = !empty && bus.res_ready;
    push     = bus.pl_valid_out && (!full || pop);
    tag_err  = bus.pl_valid_out != tag_v_q[LATENCY-1];
    wr_entry = '{id: tag_id_q[LATENCY-1], arctan_en: bus.pl_arctan_en_out,
                 sector: bus.pl_sector_out, degree: bus.pl_degree_out,
                 x: bus.pl_x_out, y: bus.pl_y_out};

    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + CW'(1);
    else if (pop && !push) occ_d = occ_q - CW'(1);

    infl_d = infl_q;
    if (issue && !bus.pl_valid_out)                        infl_d = infl_q + FW'(1);
    else if (!issue && bus.pl_valid_out && infl_q != '0)   infl_d = infl_q - FW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q    <= '0;
      infl_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
      rr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      tag_v_q  <= {tag_v_q[LATENCY-2:0], issue};
      tag_id_q <= {tag_id_q[LATENCY-2:0], gnt_id};
      if (push)    wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (issue)   rr_q     <= !gnt_id;
      if (tag_err) err_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head fields read as zero while empty, which also covers reset.
  assign res_e             = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.res_valid     = !empty;
  assign bus.res_id        = res_e.id;
  assign bus.res_arctan_en = res_e.arctan_en;
  assign bus.res_sector    = res_e.sector;
  assign bus.res_degree    = res_e.degree;
  assign bus.res_x         = res_e.x;
  assign bus.res_y         = res_e.y;
  assign bus.err_tag       = err_q;
endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: a delay-line stand-in for the CORDIC pipeline, an
// arbitration table, hand sequences for credit/reset/tag corners, and randomized traffic.
module tb_cordic_scheduler;
  localparam int DW = 16, SW = 2, LAT = 6, DEPTH = 8;
  localparam int EW = 2 + SW + 3 * DW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cordic_scheduler_if #(.DATA_WIDTH(DW), .SECTOR_FLAG_WIDTH(SW)) bus();

  cordic_scheduler #(.DATA_WIDTH(DW), .SECTOR_FLAG_WIDTH(SW), .LATENCY(LAT), .RESULT_DEPTH(DEPTH))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // ---------------- pipeline stand-in: pure LAT-cycle delay, shares reset
  logic          pv [LAT];
  logic          pa [LAT];
  logic [SW-1:0] ps [LAT];
  logic [DW-1:0] pd [LAT], px [LAT], py [LAT];
  logic          inject = 1'b0;
  logic          inj_arc = 1'b1;
  logic [SW-1:0] inj_sec = 2'd3;
  logic [DW-1:0] inj_deg = 16'h1234, inj_x = 16'h5678, inj_y = 16'h9ABC;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0; pa[i] <= 1'b0; ps[i] <= '0; pd[i] <= '0; px[i] <= '0; py[i] <= '0;
      end
    end else begin
      pv[0] <= bus.pl_valid; pa[0] <= bus.pl_arctan_en; ps[0] <= bus.pl_sector;
      pd[0] <= bus.pl_degree; px[0] <= bus.pl_x; py[0] <= bus.pl_y;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1]; pa[i] <= pa[i-1]; ps[i] <= ps[i-1];
        pd[i] <= pd[i-1]; px[i] <= px[i-1]; py[i] <= py[i-1];
      end
    end
  end

  assign bus.pl_valid_out     = pv[LAT-1] | inject;
  assign bus.pl_arctan_en_out = inject ? inj_arc : pa[LAT-1];
  assign bus.pl_sector_out    = inject ? inj_sec : ps[LAT-1];
  assign bus.pl_degree_out    = inject ? inj_deg : pd[LAT-1];
  assign bus.pl_x_out         = inject ? inj_x   : px[LAT-1];
  assign bus.pl_y_out         = inject ? inj_y   : py[LAT-1];

  // ---------------- checking helpers
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_res();
    return {bus.res_id, bus.res_arctan_en, bus.res_sector, bus.res_degree, bus.res_x, bus.res_y};
  endfunction

  function automatic logic [EW-2:0] pack_pl();
    return {bus.pl_arctan_en, bus.pl_sector, bus.pl_degree, bus.pl_x, bus.pl_y};
  endfunction

  // ---------------- reference model: credit = issued - popped < DEPTH, round-robin tie break,
  // each accepted op becomes visible LAT+1 cycles after issue, in issue order
  bit             mon_en = 1'b0;
  bit             prio   = 1'b0;
  bit             m_g0   = 1'b0, m_g1 = 1'b0;
  int             issued = 0, popped = 0, cyc = 0;
  logic [EW-1:0]  exp_q[$];
  int             exp_t[$];

  always @(posedge clk) cyc++;

  task automatic model_clear();
    prio = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0; issued = 0; popped = 0;
    exp_q.delete(); exp_t.delete();
  endtask

  always @(negedge clk) begin
    bit g, gid, exp_rv;
    logic [EW-2:0] exp_pl;
    if (mon_en) begin
      g = 1'b0; gid = 1'b0;
      if ((issued - popped) < DEPTH && (bus.r0_valid || bus.r1_valid)) begin
        g   = 1'b1;
        gid = (bus.r0_valid && bus.r1_valid) ? prio : bus.r1_valid;
      end
      chk("r0_ready", 64'(bus.r0_ready), 64'(g && !gid));
      chk("r1_ready", 64'(bus.r1_ready), 64'(g && gid));
      exp_pl = '0;
      if (g) exp_pl = gid ? {bus.r1_arctan_en, bus.r1_sector, bus.r1_degree, bus.r1_x, bus.r1_y}
                          : {bus.r0_arctan_en, bus.r0_sector, bus.r0_degree, bus.r0_x, bus.r0_y};
      chk("pl_valid", 64'(bus.pl_valid), 64'(g));
      chk("pl_fields", 64'(pack_pl()), 64'(exp_pl));
      m_g0 = g && !gid;
      m_g1 = g && gid;
      if (g) begin
        exp_q.push_back({gid, exp_pl});
        exp_t.push_back(cyc + LAT + 1);
        issued++;
        prio = !gid;
      end
      exp_rv = (exp_q.size() > 0) && (exp_t[0] <= cyc);
      chk("res_valid", 64'(bus.res_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("res_head", 64'(pack_res()), 64'(exp_q[0]));
        if (bus.res_ready) begin
          void'(exp_q.pop_front());
          void'(exp_t.pop_front());
          popped++;
        end
      end
    end
  end

  // ---------------- drivers
  task automatic rand_fields(input bit n);
    if (!n) begin
      bus.r0_arctan_en = 1'($urandom_range(0, 1)); bus.r0_sector = SW'($urandom);
      bus.r0_degree = DW'($urandom); bus.r0_x = DW'($urandom); bus.r0_y = DW'($urandom);
    end else begin
      bus.r1_arctan_en = 1'($urandom_range(0, 1)); bus.r1_sector = SW'($urandom);
      bus.r1_degree = DW'($urandom); bus.r1_x = DW'($urandom); bus.r1_y = DW'($urandom);
    end
  endtask

  // Fields only change once the previous offer was taken or withdrawn.
  task automatic drive(input bit v0, input bit v1);
    if (!bus.r0_valid || m_g0) rand_fields(1'b0);
    if (!bus.r1_valid || m_g1) rand_fields(1'b1);
    bus.r0_valid = v0;
    bus.r1_valid = v1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.res_ready = 1'b0; inject = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0);
    end
  endtask

  typedef struct { bit v0; bit v1; bit e0; bit e1; } arb_vec_t;
  arb_vec_t tbl [13];

  initial begin
    int lat, ng;
    bit rv0, rv1;
    tbl = '{'{1,1,1,0}, '{0,1,0,1}, '{1,0,1,0}, '{1,0,1,0}, '{1,1,0,1}, '{1,0,1,0}, '{0,1,0,1},
            '{0,0,0,0}, '{1,1,1,0}, '{0,1,0,1}, '{0,0,0,0}, '{1,1,1,0}, '{0,1,0,1}};

    // outputs stay quiet while reset is held, even with requests pending
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1; bus.res_ready = 1'b1;
    rand_fields(1'b0); rand_fields(1'b1);
    #12;
    chk("rst_r0_ready", 64'(bus.r0_ready), 64'(0));
    chk("rst_r1_ready", 64'(bus.r1_ready), 64'(0));
    chk("rst_pl_valid", 64'(bus.pl_valid), 64'(0));
    chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_err_tag", 64'(bus.err_tag), 64'(0));
    do_reset();

    // arbitration table, no backpressure
    bus.res_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].v0, tbl[i].v1);
      @(negedge clk);
      chk($sformatf("tbl%0d_r0_ready", i), 64'(bus.r0_ready), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_r1_ready", i), 64'(bus.r1_ready), 64'(tbl[i].e1));
    end
    idle(LAT + 3);

    // single rotation: 45 degrees, sector 2, result visible LAT+1 cycles later
    do_reset();
    @(posedge clk); #1;
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b0; bus.r0_arctan_en = 1'b0; bus.r0_sector = 2'd2;
    bus.r0_degree = 16'h2D00; bus.r0_x = 16'h00B5; bus.r0_y = 16'h00B5;
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rot_latency", 64'(lat), 64'(LAT + 1));
    chk("rot_id", 64'(bus.res_id), 64'(0));
    chk("rot_sector", 64'(bus.res_sector), 64'(2));
    chk("rot_degree", 64'(bus.res_degree), 64'(16'h2D00));
    chk("rot_x", 64'(bus.res_x), 64'(16'h00B5));
    chk("rot_y", 64'(bus.res_y), 64'(16'h00B5));
    bus.res_ready = 1'b1;
    idle(3);

    // contention: both streaming, grants alternate starting with r0
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("cont%0d_r0_ready", i), 64'(bus.r0_ready), 64'((i % 2) == 0));
    end
    idle(LAT + 3);

    // backpressure: exactly DEPTH issues, then stall
    do_reset();
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1);
      @(negedge clk);
      ng += int'(bus.r0_ready) + int'(bus.r1_ready);
    end
    chk("bp_issues", 64'(ng), 64'(DEPTH));
    chk("bp_stalled", 64'({bus.r0_ready, bus.r1_ready}), 64'(0));
    // one pop frees one credit, usable only in the following cycle
    @(posedge clk); #1;
    drive(1'b1, 1'b1); bus.res_ready = 1'b1;
    @(negedge clk);
    chk("rel_same_cycle", 64'(bus.r0_ready | bus.r1_ready), 64'(0));
    @(posedge clk); #1;
    drive(1'b1, 1'b1); bus.res_ready = 1'b0;
    @(negedge clk);
    chk("rel_one_credit", 64'(int'(bus.r0_ready) + int'(bus.r1_ready)), 64'(1));
    @(posedge clk); #1;
    drive(1'b1, 1'b1);
    @(negedge clk);
    chk("rel_no_more", 64'(bus.r0_ready | bus.r1_ready), 64'(0));
    idle(LAT + 3);

    // full FIFO: spurious return pushed in the same cycle as a pop
    @(posedge clk); #1;
    mon_en = 1'b0;
    inject = 1'b1; bus.res_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_head", 64'(pack_res()), 64'(exp_q[0]));
    void'(exp_q.pop_front());
    chk("tag_err_not_yet", 64'(bus.err_tag), 64'(0));
    @(posedge clk); #1;
    inject = 1'b0; bus.res_ready = 1'b0; bus.r0_valid = 1'b1;
    @(negedge clk);
    chk("tag_err_set", 64'(bus.err_tag), 64'(1));
    chk("full_no_credit", 64'(bus.r0_ready), 64'(0));
    @(posedge clk); #1;
    bus.r0_valid = 1'b0; bus.res_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_valid", i), 64'(bus.res_valid), 64'(1));
      if (i < DEPTH - 1) begin
        chk($sformatf("drain%0d_data", i), 64'(pack_res()), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        chk("drain_spurious", 64'(pack_res() & {1'b0, {(EW-1){1'b1}}}),
            64'({1'b0, inj_arc, inj_sec, inj_deg, inj_x, inj_y}));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_empty", 64'(bus.res_valid), 64'(0));
    chk("tag_err_sticky", 64'(bus.err_tag), 64'(1));

    // reset with four operations in flight discards everything
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_err_clear", 64'(bus.err_tag), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("midrst%0d_res_valid", i), 64'(bus.res_valid), 64'(0));
      chk($sformatf("midrst%0d_err_tag", i), 64'(bus.err_tag), 64'(0));
    end

    // randomized traffic against the model
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rv0 = (bus.r0_valid && !m_g0) ? 1'b1 : ($urandom_range(0, 99) < 60);
      rv1 = (bus.r1_valid && !m_g1) ? 1'b1 : ($urandom_range(0, 99) < 60);
      drive(rv0, rv1);
      bus.res_ready = ($urandom_range(0, 99) < 45);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0);
    bus.res_ready = 1'b1;
    idle(LAT + DEPTH + 4);
    chk("final_drained", 64'(exp_q.size()), 64'(0));
    chk("final_err_tag", 64'(bus.err_tag), 64'(0));
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
